// File: rtl/mem_read_pipe.sv
// Dual-port (1W/1R) memory with a registered, LATENCY-deep read pipeline and valid strobe.
// Optional macro MEM_READ_PIPE_BYPASS_EN: same-edge same-address read returns the write data.
module mem_read_pipe #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_wen,
  input  logic [ADDR_W-1:0] io_waddr,
  input  logic [WIDTH-1:0]  io_wdata,
  input  logic              io_ren,
  input  logic [ADDR_W-1:0] io_raddr,
  output logic [WIDTH-1:0]  io_out,
  output logic              io_out_valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] stage1_d;
  logic [WIDTH-1:0] data_q [LATENCY];
  logic [LATENCY-1:0] valid_q;

  assign waddr = io_waddr[AW-1:0];
  assign raddr = io_raddr[AW-1:0];

  generate
    if (ADDR_W > AW) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^{io_waddr[ADDR_W-1:AW], io_raddr[ADDR_W-1:AW]};
    end
  endgenerate

`ifndef SYNTHESIS
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
  end
`endif

  // Memory has no reset so a write coincident with reset still lands.
  always_ff @(posedge clk) begin
    if (io_wen) mem[waddr] <= io_wdata;
  end

`ifdef MEM_READ_PIPE_BYPASS_EN
  assign stage1_d = (io_wen && (waddr == raddr)) ? io_wdata : mem[raddr];
`else
  assign stage1_d = mem[raddr];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q[0] <= 1'b0;
      data_q[0]  <= '0;
    end else begin
      valid_q[0] <= io_ren;
      if (io_ren) data_q[0] <= stage1_d;
    end
  end

  // Later stages only load on an incoming valid so the output holds between reads.
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_q[gi-1];
          if (valid_q[gi-1]) data_q[gi] <= data_q[gi-1];
        end
      end
    end
  endgenerate

  assign io_out       = data_q[LATENCY-1];
  assign io_out_valid = valid_q[LATENCY-1];

endmodule

// File: doc/mem_read_pipe.md
# mem_read_pipe

- Parametrised successor to the single-port combinational memory read block.
- Adds a write port, a registered read with configurable pipeline depth, and a valid strobe tracking every read through the pipe.
- Sits between address-generation logic and downstream consumers that need fixed, known read latency.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 8: number of words; must be a power of two, at least 2.
- ADDR_W, 32: width of the address ports; only the low log2(DEPTH) bits are used.
- LATENCY, 1: read latency in cycles, 1..4.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- io_wen  input  1  write enable.
- io_waddr  input  ADDR_W  write address.
- io_wdata  input  WIDTH  write data.
- io_ren  input  1  read request.
- io_raddr  input  ADDR_W  read address.
- io_out  output  WIDTH  read data.
- io_out_valid  output  1  high for exactly one cycle per accepted read, aligned with its data.

## Operation
- **Address mapping.** Both addresses are truncated to bits [log2(DEPTH)-1:0]. Upper bits are ignored, so addresses wrap (DEPTH=8: address 9 maps to word 1).
- **Write.** When io_wen=1 at a clock edge, mem[waddr] <= io_wdata.
- **Read acceptance.** A read is accepted on every edge with io_ren=1. There is no backpressure, and one read can be issued per cycle indefinitely.
- **Stage 1.** Samples mem[raddr] at the accept edge.
- **Stages 2..LATENCY.** Plain register stages, each carrying a data word and a valid bit.
- **Output.** io_out/io_out_valid come from the last stage.
- **Hold behaviour.** A stage's data register loads only when its incoming valid bit is 1. With no reads, io_out holds the last delivered word.
- **Ordering.** Back-to-back reads come out in issue order, one per cycle, with no gaps.
- **Writes after acceptance.** A write on any edge after a read's accept edge does not change that read's in-flight data.
- **Read-during-write, same edge, same truncated address.** Behaviour is selected by the Configuration macro below.
- **Same edge, different addresses.** The read and the write are independent.
- **Reset effects.**
  - All valid bits clear, which discards in-flight reads.
  - Stage data registers and io_out reset to 0.
  - Memory contents are not reset.
  - A write coincident with reset still commits.
  - A read coincident with reset is dropped.
- **Simulation-only initialisation.** Memory is initialised to random values (not under SYNTHESIS).

## Timing
- Reset values: io_out=0, io_out_valid=0.
- Read latency is exactly LATENCY cycles.
  - A read accepted at edge N gives io_out_valid=1 and valid io_out during the cycle after edge N+LATENCY-1.
  - LATENCY=1: data appears the cycle after the request.
- Write-to-read visibility: a read accepted at the edge after a write's edge always returns the new data.
- Reset released at edge R: a read may be accepted at edge R+1.

## Configuration
- Macro: `MEM_READ_PIPE_BYPASS_EN`.
- **Defined:** on a same-edge, same-address read and write, stage 1 captures io_wdata (write-first / new data).
- **Undefined:** stage 1 captures the pre-write memory word (read-first / old data).
- The memory itself is written identically in both cases.

## Test plan
- **Basic read, LATENCY=1, DEPTH=8.**
  - Write 0xDEADBEEF to address 3, then read address 3.
  - Required: io_out=0xDEADBEEF with io_out_valid=1 exactly one cycle after the read edge; valid low in the next cycle; io_out still 0xDEADBEEF there.
- **Address wrap, DEPTH=8.**
  - Write 0x11 to address 0x0000000B, then read address 3.
  - Required: returns 0x11.
- **Pipeline streaming, LATENCY=3.**
  - Fill words 0..7 with 0x100+i, then issue 8 back-to-back reads of addresses 7..0.
  - Required: valid high for 8 consecutive cycles starting 3 cycles after the first read; data 0x107, 0x106, ... 0x100 in order.
- **Read-during-write.**
  - Word 5 = 0xAAAA. On one edge, write 0xBBBB to 5 and read 5.
  - Required: 0xBBBB with the macro defined, 0xAAAA without it. A following read of 5 returns 0xBBBB in both builds.
- **In-flight isolation, LATENCY=4.**
  - Read word 2 (=0x22); write 0x99 to word 2 on the next edge.
  - Required: the read delivers 0x22.
- **Reset mid-operation, LATENCY=4.**
  - Issue reads on 2 edges, then assert reset for 1 cycle.
  - Required: io_out_valid never rises for those reads; io_out=0 after reset; a subsequent read of a previously written word returns the pre-reset contents.
